// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, IF/ID update
// selects, the NOP encoding and the PC increment helper.
package fetch_pkg;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    localparam logic [1:0] IFID_HOLD   = 2'd0;
    localparam logic [1:0] IFID_MEM    = 2'd1;
    localparam logic [1:0] IFID_SKID   = 2'd2;
    localparam logic [1:0] IFID_BUBBLE = 2'd3;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_ENC = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } skid_entry_t;

    // Wraps naturally at 32 bits: 32'hFFFF_FFFC -> 32'h0000_0000.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a word fetched while decode was stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter logic [31:0] CLEAR_INSTR = NOP_INSTR_ENC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output skid_entry_t o_entry
);

    skid_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_entry <= '{valid: 1'b0, instr: CLEAR_INSTR, pc: 32'h0};
        end else if (i_load) begin
            r_entry <= '{valid: 1'b1, instr: i_instr, pc: i_pc};
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem request handshake, skid buffer and IF/ID register,
// with decode stalls and EX/MEM branch redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_ENC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_stage_if.master      imem,
    output logic               ifid_valid,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_pc4
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_next;
    logic        w_skid_load;
    logic        w_skid_clear;
    logic [1:0]  w_ifid_sel;
    skid_entry_t w_skid;

    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;

    // The request is gated by reset so an in-flight fetch is dropped immediately.
    assign imem.imem_req  = !reset && (r_state != ST_HELD);
    assign imem.imem_addr = r_pc;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_tgt_next   = r_tgt;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        // Redirect flushes and beats stall; stall holds; otherwise a bubble.
        if (redirect) begin
            w_ifid_sel = IFID_BUBBLE;
        end else if (stall) begin
            w_ifid_sel = IFID_HOLD;
        end else begin
            w_ifid_sel = IFID_BUBBLE;
        end

        case (r_state)
            ST_FETCH: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        w_pc_next = redirect_pc;
                    end else begin
                        w_tgt_next   = redirect_pc;
                        w_state_next = ST_DISCARD;
                    end
                end else if (imem.imem_ready) begin
                    w_pc_next = pc_inc(r_pc);
                    if (stall) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_HELD;
                    end else begin
                        w_ifid_sel = IFID_MEM;
                    end
                end
            end
            ST_DISCARD: begin
                // The stale response completes the bus cycle and is thrown away.
                if (imem.imem_ready) begin
                    w_pc_next    = redirect ? redirect_pc : r_tgt;
                    w_state_next = ST_FETCH;
                end else if (redirect) begin
                    w_tgt_next = redirect_pc;
                end
            end
            ST_HELD: begin
                if (redirect) begin
                    w_skid_clear = 1'b1;
                    w_pc_next    = redirect_pc;
                    w_state_next = ST_FETCH;
                end else if (!stall) begin
                    w_skid_clear = 1'b1;
                    w_ifid_sel   = IFID_SKID;
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_tgt   <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_tgt   <= w_tgt_next;
        end
    end

    fetch_skid_buf #(
        .CLEAR_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem.imem_rdata),
        .i_pc    (r_pc),
        .o_entry (w_skid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 32'h0;
            r_ifid_pc4   <= 32'h0;
        end else begin
            case (w_ifid_sel)
                IFID_MEM: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_instr <= imem.imem_rdata;
                    r_ifid_pc    <= r_pc;
                    r_ifid_pc4   <= pc_inc(r_pc);
                end
                IFID_SKID: begin
                    r_ifid_valid <= w_skid.valid;
                    r_ifid_instr <= w_skid.valid ? w_skid.instr : NOP_INSTR;
                    r_ifid_pc    <= w_skid.pc;
                    r_ifid_pc4   <= pc_inc(w_skid.pc);
                end
                IFID_BUBBLE: begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_instr <= NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_pc4   = r_ifid_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word at address a is (a>>2)+1.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    int checks_count;
    int errors_count;

    fetch_stage_if imem_bus();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    assign imem_bus.imem_ready = ready;
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            errors_count++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_count = 0;
        errors_count = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b1;

        // Reset values
        #1;
        check_value("rst_req", {31'h0, imem_bus.imem_req}, 32'h0);
        tick();
        check_value("rst_valid", {31'h0, ifid_valid}, 32'h0);
        check_value("rst_instr", ifid_instr, 32'h0);
        check_value("rst_pc", ifid_pc, 32'h0);
        check_value("rst_pc4", ifid_pc4, 32'h0);
        reset = 1'b0;
        #1;
        check_value("rst_addr", imem_bus.imem_addr, 32'h0);
        check_value("req_up", {31'h0, imem_bus.imem_req}, 32'h1);

        // 1: streaming at one instruction per cycle
        for (int k = 0; k < 4; k++) begin
            check_value("s_addr", imem_bus.imem_addr, 32'(4 * k));
            tick();
            check_value("s_valid", {31'h0, ifid_valid}, 32'h1);
            check_value("s_instr", ifid_instr, 32'(k + 1));
            check_value("s_pc", ifid_pc, 32'(4 * k));
            check_value("s_pc4", ifid_pc4, 32'(4 * k + 4));
        end

        // 2: three-cycle stall with ready=1; one word goes to the skid buffer
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("st_instr", ifid_instr, 32'h4);
            check_value("st_pc", ifid_pc, 32'hC);
            check_value("st_req", {31'h0, imem_bus.imem_req}, 32'h0);
        end
        stall = 1'b0;
        tick();
        check_value("st_skid_instr", ifid_instr, 32'h5);
        check_value("st_skid_pc", ifid_pc, 32'h10);
        check_value("st_skid_valid", {31'h0, ifid_valid}, 32'h1);
        check_value("st_next_addr", imem_bus.imem_addr, 32'h14);
        tick();
        check_value("st_after_instr", ifid_instr, 32'h6);
        check_value("st_after_pc", ifid_pc, 32'h14);

        // 3: redirect during a request with two wait states
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check_value("rd_addr_hold1", imem_bus.imem_addr, 32'h18);
        check_value("rd_req_hold1", {31'h0, imem_bus.imem_req}, 32'h1);
        check_value("rd_flush", {31'h0, ifid_valid}, 32'h0);
        tick();
        check_value("rd_addr_hold2", imem_bus.imem_addr, 32'h18);
        check_value("rd_gap_valid", {31'h0, ifid_valid}, 32'h0);
        ready = 1'b1;
        tick();
        check_value("rd_new_addr", imem_bus.imem_addr, 32'h40);
        check_value("rd_drop_valid", {31'h0, ifid_valid}, 32'h0);
        check_value("rd_drop_instr", ifid_instr, 32'h0);
        tick();
        check_value("rd_tgt_instr", ifid_instr, 32'h11);
        check_value("rd_tgt_pc", ifid_pc, 32'h40);
        check_value("rd_tgt_pc4", ifid_pc4, 32'h44);

        // 4: redirect and stall in the same cycle
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        check_value("rs_valid", {31'h0, ifid_valid}, 32'h0);
        check_value("rs_instr", ifid_instr, 32'h0);
        check_value("rs_addr", imem_bus.imem_addr, 32'h100);
        tick();
        check_value("rs_tgt_instr", ifid_instr, 32'h41);
        check_value("rs_tgt_pc", ifid_pc, 32'h100);

        // Repeated redirects while discarding: latest target wins
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        check_value("lw_addr_hold", imem_bus.imem_addr, 32'h104);
        ready = 1'b1;
        tick();
        check_value("lw_addr", imem_bus.imem_addr, 32'h300);
        tick();
        check_value("lw_instr", ifid_instr, 32'hC1);

        // 5: reset in the middle of a request
        ready = 1'b0;
        reset = 1'b1;
        #1;
        check_value("mr_req", {31'h0, imem_bus.imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        check_value("mr_valid", {31'h0, ifid_valid}, 32'h0);
        check_value("mr_addr", imem_bus.imem_addr, 32'h0);
        #1;
        check_value("mr_req_up", {31'h0, imem_bus.imem_req}, 32'h1);

        // 6: PC wrap at the top of the address space
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check_value("wr_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_value("wr_addr_wrap", imem_bus.imem_addr, 32'h0);
        check_value("wr_instr", ifid_instr, 32'h4000_0000);
        check_value("wr_pc", ifid_pc, 32'hFFFF_FFFC);
        check_value("wr_pc4", ifid_pc4, 32'h0);
        tick();
        check_value("wr_next_instr", ifid_instr, 32'h1);
        check_value("wr_next_pc", ifid_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_count, errors_count);
        $finish;
    end

endmodule
